// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: op encodings and output-register states.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op);
    return op <= ALU_XOR;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scan starts at ptr_i and wraps; first valid wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDW     = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     gnt_idx_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ requesters with round-robin arbitration and a
// single-entry valid/ready result register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [ALU_OP_W*NUM_REQ-1:0] req_op,
  input  logic [WIDTH*NUM_REQ-1:0]    req_a,
  input  logic [WIDTH*NUM_REQ-1:0]    req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [IDW-1:0]              rsp_id,
  output logic [WIDTH-1:0]            rsp_result,
  output logic                        rsp_zero,
  output logic                        rsp_illegal
);

  function automatic logic [WIDTH-1:0] alu_eval(input logic [ALU_OP_W-1:0] op,
                                                input logic [WIDTH-1:0]    a,
                                                input logic [WIDTH-1:0]    b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return '0;
    endcase
  endfunction

  logic [0:0]         state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic               can_accept;
  logic               accept;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic [ALU_OP_W-1:0] op_sel;
  logic [WIDTH-1:0]   a_sel, b_sel, alu_res;
  int unsigned        ptr_nxt;

  // Reset gates the arbiter so nothing is accepted in a reset cycle.
  assign can_accept = (state_q == ST_EMPTY) || rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .en_i      (can_accept && !rst),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |(req_valid & gnt);

  always_comb begin
    op_sel = '0;
    a_sel  = '0;
    b_sel  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        op_sel = req_op[i*ALU_OP_W +: ALU_OP_W];
        a_sel  = req_a[i*WIDTH +: WIDTH];
        b_sel  = req_b[i*WIDTH +: WIDTH];
      end
    end
    alu_res = alu_eval(op_sel, a_sel, b_sel);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    ptr_nxt   = (int'(gnt_idx) + 1) % NUM_REQ;
    if (accept) begin
      state_d   = ST_FULL;
      ptr_d     = IDW'(ptr_nxt);
      id_d      = gnt_idx;
      result_d  = alu_res;
      zero_d    = (alu_res == '0);
      illegal_d = !op_is_legal(op_sel);
    end else if (state_q == ST_FULL && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      ptr_q     <= '0;
      id_q      <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign rsp_valid   = (state_q == ST_FULL);
  assign rsp_id      = id_q;
  assign rsp_result  = result_q;
  assign rsp_zero    = zero_q;
  assign rsp_illegal = illegal_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with two 32-bit requesters.
module tb_alu_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned IDW     = 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [3*NUM_REQ-1:0]   req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_zero;
  logic                   rsp_illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .IDW     (IDW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    req_op[i*3 +: 3]      = op;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [IDW-1:0] id,
                         input logic [31:0] res, input logic z, input logic ill);
    chk({tag, ".valid"}, 64'(rsp_valid), 64'(v));
    chk({tag, ".id"}, 64'(rsp_id), 64'(id));
    chk({tag, ".result"}, 64'(rsp_result), 64'(res));
    chk({tag, ".zero"}, 64'(rsp_zero), 64'(z));
    chk({tag, ".illegal"}, 64'(rsp_illegal), 64'(ill));
  endtask

  initial begin
    logic [1:0] exp_gnt;
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk_rsp("reset", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset.req_ready", 64'(req_ready), 64'h0);
    rst = 1'b0;

    // Single request, no backpressure
    rsp_ready = 1'b1;
    set_req(0, 3'b000, 32'd5, 32'd7);
    req_valid = 2'b01;
    #1;
    chk("single.req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk_rsp("single", 1'b1, 1'b0, 32'd12, 1'b0, 1'b0);
    tick();
    chk("single.drain", 64'(rsp_valid), 64'h0);

    // Round-robin fairness from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 3'b001, 32'd3, 32'd3);
    set_req(1, 3'b100, 32'hFF, 32'h0F);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk($sformatf("rr%0d.req_ready", k), 64'(req_ready), 64'(exp_gnt));
      tick();
      if (k % 2 == 0) chk_rsp($sformatf("rr%0d", k), 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      else            chk_rsp($sformatf("rr%0d", k), 1'b1, 1'b1, 32'hF0, 1'b0, 1'b0);
    end
    req_valid = 2'b00;
    tick();

    // Backpressure: hold req1's result while req0 waits
    set_req(1, 3'b011, 32'hA, 32'h5);
    req_valid = 2'b10;
    #1;
    chk("bp.accept1", 64'(req_ready), 64'h2);
    tick();
    set_req(0, 3'b000, 32'd1, 32'd2);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("bp%0d.req_ready", k), 64'(req_ready), 64'h0);
      chk_rsp($sformatf("bp%0d", k), 1'b1, 1'b1, 32'hF, 1'b0, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp.release.req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 2'b00;
    chk_rsp("bp.next", 1'b1, 1'b0, 32'd3, 1'b0, 1'b0);
    tick();

    // Wrap-around arithmetic and illegal ops, back to back on req0
    req_valid = 2'b01;
    set_req(0, 3'b000, 32'hFFFF_FFFF, 32'd1);
    tick();
    chk_rsp("add_wrap", 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    set_req(0, 3'b001, 32'd0, 32'd1);
    tick();
    chk_rsp("sub_wrap", 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    set_req(0, 3'b111, 32'd3, 32'd4);
    tick();
    chk_rsp("op111", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    set_req(0, 3'b010, 32'hF0F0, 32'hFF00);
    tick();
    chk_rsp("and", 1'b1, 1'b0, 32'hF000, 1'b0, 1'b0);
    set_req(0, 3'b101, 32'h1234, 32'h1);
    tick();
    chk_rsp("op101", 1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    req_valid = 2'b00;
    tick();

    // Reset while a result is held
    set_req(1, 3'b011, 32'h1, 32'h2);
    req_valid = 2'b10;
    tick();
    rsp_ready = 1'b0;
    tick();
    chk_rsp("held", 1'b1, 1'b1, 32'h3, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst.req_ready", 64'(req_ready), 64'h0);
    tick();
    rst = 1'b0;
    chk_rsp("after_rst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    set_req(0, 3'b000, 32'd10, 32'd20);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    chk("after_rst.req_ready", 64'(req_ready), 64'h1);
    tick();
    chk_rsp("after_rst.first", 1'b1, 1'b0, 32'd30, 1'b0, 1'b0);
    req_valid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU datapath among NUM_REQ requesters, for example the execute stage, the branch-target adder and a debug port.
- Arbitrates round-robin and evaluates the selected operation in the accept cycle.
- Holds the result in a single-entry output register with valid/ready backpressure.
- Sits between the requesting units and the shared ALU; it sequences access and ownership of results.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- WIDTH, 32, operand/result width.
- IDW, 1, requester-id width = clog2(NUM_REQ), minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_op  in  3*NUM_REQ  per-requester op, slice i = [3i+2:3i].
- req_a  in  WIDTH*NUM_REQ  per-requester operand A.
- req_b  in  WIDTH*NUM_REQ  per-requester operand B.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_result  out  WIDTH  ALU result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_illegal  out  1  op was not a defined encoding.

Behaviour:
- Op encodings:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101/110/111 are illegal: result forced to 0, rsp_illegal=1, rsp_zero=1.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no carry or overflow outputs.
- Output register states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY, or (FULL and rsp_ready). A drain and a new accept in the same cycle are allowed, giving full throughput of one op per cycle.
- Grant selection:
  - Scan starts at priority pointer ptr and wraps, ptr, ptr+1, ... mod NUM_REQ.
  - The first i with req_valid[i]=1 is granted.
- req_ready[i] = grant[i] & can_accept. It is combinational from req_valid and the state.
- Accept happens when req_valid[i] & req_ready[i] at edge t:
  - At t+1: rsp_valid=1, rsp_id=i, rsp_result/zero/illegal computed from requester i's operands sampled at t.
  - Latency is exactly 1 cycle.
- Pointer update: after an accept from i, ptr <= (i+1) mod NUM_REQ. With no accept, ptr is unchanged.
- Transitions:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on rsp_ready with no accept.
  - FULL stays FULL (new data) on rsp_ready with an accept.
  - FULL stays FULL (data held) when rsp_ready=0.
- Stability: while rsp_valid=1 and rsp_ready=0, rsp_id, rsp_result, rsp_zero and rsp_illegal hold constant, and all req_ready=0.
- Requesters: req_valid, once raised, is held with stable payload until accepted. The block does not check this.
- rsp_ready while EMPTY is ignored.
- Reset (rst=1 at an edge):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_illegal=0, ptr=0.
  - Any held result is discarded.
  - req_ready=0 during any cycle in which rst=1.
  - A request presented in the reset cycle is not accepted.
- NUM_REQ=1 degenerates to a pass-through register with IDW=1 and rsp_id=0.

Decomposition:
- Shared package alu_pkg:
  - Op constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_XOR=3'b100.
  - Op width ALU_OP_W=3.
  - Output-state encoding ST_EMPTY/ST_FULL.
- One sub-module rr_arbiter:
  - Inputs: NUM_REQ request vector, ptr, enable.
  - Outputs: one-hot grant and the granted index.
  - Pure combinational.
- The pointer register and the result register live in alu_arbiter.
- The ALU evaluation is a combinational function on the muxed operands.

Test Plan:
- Single request, no backpressure:
  - Stimulus: req0 add a=5 b=7 at cycle 3, rsp_ready=1.
  - Required: req_ready[0]=1 at cycle 3; at cycle 4 rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- Round-robin fairness:
  - Stimulus: both requesters valid continuously with rsp_ready=1 from reset; req0 sub 3-3, req1 xor FF^0F.
  - Required: grant order 0,1,0,1.
  - Required results: result 0 with rsp_zero=1 for id 0; result F0 for id 1.
- Backpressure:
  - Stimulus: accept req1 or 0xA|0x5, then rsp_ready=0 for 4 cycles while req0 stays valid.
  - Required: rsp_result=0xF and rsp_id=1 held for 4 cycles; req_ready=0.
  - Stimulus: rsp_ready=1.
  - Required: req0 accepted in the same cycle; its result appears the next cycle.
- Wrap and illegal ops:
  - Stimulus: add 0xFFFFFFFF+1.
  - Required: result 0, zero=1.
  - Stimulus: sub 0-1.
  - Required: result 0xFFFFFFFF.
  - Stimulus: op 111 with a=3, b=4.
  - Required: result 0, rsp_illegal=1, rsp_zero=1.
- Reset mid-operation:
  - Stimulus: result held with rsp_ready=0, then rst=1 for one cycle while req1 is valid.
  - Required: next cycle rsp_valid=0 and all outputs 0; req1 is not accepted in the rst cycle.
  - Required: after release, with both requesters valid, req0 is granted first (ptr=0).
